// File: rtl/cfi_log_queue.sv
// cfi_log_queue: CFI front end between commit and the CFI checker.
// Classifies committing control-flow instructions, qualifies them against
// per-privilege type masks and programmable PC windows, and compacts the
// qualified logs in port order into a DEPTH-entry FIFO drained over
// valid/ready.
// Optional feature macro: CFI_LOG_DROP_CNT_EN adds the saturating 16-bit
// drop_cnt_o counter of discarded logs.

package cfi_log_pkg;
  localparam int unsigned VLEN = 32;

  localparam logic [3:0] FU_CTRL_FLOW = 4'd4;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_EQ   = 8'h10;
  localparam logic [7:0] OP_NE   = 8'h11;
  localparam logic [7:0] OP_LTS  = 8'h12;
  localparam logic [7:0] OP_GES  = 8'h13;
  localparam logic [7:0] OP_LTU  = 8'h14;
  localparam logic [7:0] OP_GEU  = 8'h15;
  localparam logic [7:0] OP_JALR = 8'h16;
  localparam logic [7:0] OP_JAL  = 8'h17;

  localparam logic [1:0] PRIV_U  = 2'b00;
  localparam logic [1:0] PRIV_S  = 2'b01;
  localparam logic [1:0] PRIV_HS = 2'b10;
  localparam logic [1:0] PRIV_M  = 2'b11;

  typedef struct packed {
    logic branch;
    logic jump;
    logic call;
    logic ret;
  } cfi_flags_t;

  typedef struct packed {
    cfi_flags_t      flags;
    logic [VLEN-1:0] addr_pc;
    logic [VLEN-1:0] addr_npc;
    logic [VLEN-1:0] addr_target;
  } cfi_log_t;

  typedef struct packed {
    logic            valid;
    logic [3:0]      fu;
    logic [7:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] result;
    logic [VLEN-1:0] predict_address;
  } scoreboard_entry_t;

  localparam int unsigned FLAGS_W = $bits(cfi_flags_t);
  localparam int unsigned LOG_W   = $bits(cfi_log_t);
  localparam int unsigned SBE_W   = $bits(scoreboard_entry_t);
endpackage

module cfi_log_queue
  import cfi_log_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned NR_ADDR_RANGES  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NR_COMMIT_PORTS*SBE_W-1:0] instr_i,
  input  logic [NR_COMMIT_PORTS-1:0]       commit_ack_i,
  input  logic [FLAGS_W-1:0]               flags_m_i,
  input  logic [FLAGS_W-1:0]               flags_h_i,
  input  logic [FLAGS_W-1:0]               flags_s_i,
  input  logic [FLAGS_W-1:0]               flags_u_i,
  input  logic [1:0]                       priv_lvl_i,
  input  logic [NR_ADDR_RANGES*VLEN-1:0]   range_start_i,
  input  logic [NR_ADDR_RANGES*VLEN-1:0]   range_limit_i,
  input  logic [NR_ADDR_RANGES-1:0]        range_en_i,
  output logic [LOG_W-1:0]                 log_o,
  output logic                             log_valid_o,
  input  logic                             log_ready_i,
  output logic [$clog2(DEPTH):0]           level_o,
  output logic                             stall_o,
  output logic                             overflow_o
`ifdef CFI_LOG_DROP_CNT_EN
  ,
  output logic [15:0]                      drop_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PORTS_C = CNT_W'(NR_COMMIT_PORTS);

  cfi_log_t                   mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       stall_q;
  logic                       overflow_q;

  scoreboard_entry_t          ent [NR_COMMIT_PORTS];
  cfi_log_t                   cand [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] is_branch;
  logic [NR_COMMIT_PORTS-1:0] is_jalr;
  logic [NR_COMMIT_PORTS-1:0] is_jal;
  logic [NR_COMMIT_PORTS-1:0] in_window;
  logic [NR_COMMIT_PORTS-1:0] qual;
  cfi_flags_t                 priv_mask;

  logic [CNT_W-1:0]           free;
  logic [CNT_W-1:0]           n_qual;
  logic [CNT_W-1:0]           n_push;
  logic [CNT_W-1:0]           n_drop;
  logic [CNT_W-1:0]           count_nxt;
  logic [NR_COMMIT_PORTS-1:0] wr_en;
  logic [PTR_W-1:0]           wr_idx [NR_COMMIT_PORTS];
  logic                       pop;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Select the type mask of the current privilege level.
  always_comb begin
    case (priv_lvl_i)
      PRIV_M:  priv_mask = cfi_flags_t'(flags_m_i);
      PRIV_HS: priv_mask = cfi_flags_t'(flags_h_i);
      PRIV_S:  priv_mask = cfi_flags_t'(flags_s_i);
      default: priv_mask = cfi_flags_t'(flags_u_i);
    endcase
  end

  // Classify each commit port, build its log and decide whether it qualifies.
  always_comb begin
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      ent[i]       = scoreboard_entry_t'(instr_i[i*SBE_W +: SBE_W]);
      is_branch[i] = (ent[i].fu == FU_CTRL_FLOW) &&
                     (ent[i].op inside {OP_EQ, OP_NE, OP_LTS, OP_GES, OP_LTU, OP_GEU});
      is_jalr[i]   = (ent[i].fu == FU_CTRL_FLOW) && (ent[i].op == OP_JALR);
      is_jal[i]    = (ent[i].fu == FU_CTRL_FLOW) && !is_branch[i] && !is_jalr[i];

      cand[i].flags.branch = is_branch[i];
      cand[i].flags.jump   = (is_jal[i] || is_jalr[i]) &&
                             !is_link(ent[i].rs1) && !is_link(ent[i].rd);
      cand[i].flags.call   = (is_jal[i] || is_jalr[i]) && is_link(ent[i].rd);
      cand[i].flags.ret    = is_jalr[i] && is_link(ent[i].rs1);
      cand[i].addr_pc      = ent[i].pc;
      cand[i].addr_npc     = ent[i].result;
      cand[i].addr_target  = ent[i].predict_address;

      // An inverted window (start >= limit) can never satisfy both bounds.
      in_window[i] = 1'b0;
      for (int unsigned j = 0; j < NR_ADDR_RANGES; j++) begin
        if (range_en_i[j] &&
            (range_start_i[j*VLEN +: VLEN] <= ent[i].pc) &&
            (ent[i].pc < range_limit_i[j*VLEN +: VLEN])) begin
          in_window[i] = 1'b1;
        end
      end

      qual[i] = ent[i].valid && commit_ack_i[i] &&
                (|(priv_mask & cand[i].flags)) && in_window[i];
    end
  end

  // Compact qualified logs onto consecutive slots; space is the registered
  // free count only, so a same-cycle pop never makes room for a push.
  always_comb begin
    free   = DEPTH_C - count_q;
    n_qual = '0;
    wr_en  = '0;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      wr_idx[i] = wr_ptr_q + n_qual[PTR_W-1:0];
      wr_en[i]  = qual[i] && (n_qual < free);
      if (qual[i]) begin
        n_qual = n_qual + CNT_W'(1);
      end
    end
    n_push    = (n_qual < free) ? n_qual : free;
    n_drop    = n_qual - n_push;
    pop       = (count_q != '0) && log_ready_i;
    count_nxt = count_q + n_push - CNT_W'(pop);
  end

  // FIFO storage, pointers, occupancy and registered status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem        <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (wr_en[i]) begin
          mem[wr_idx[i]] <= cand[i];
        end
      end
      wr_ptr_q <= wr_ptr_q + n_push[PTR_W-1:0];
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q    <= count_nxt;
      stall_q    <= (DEPTH_C - count_nxt) < PORTS_C;
      overflow_q <= (n_drop != '0);
    end
  end

`ifdef CFI_LOG_DROP_CNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt_o} + 17'(n_drop);

  // Saturating count of discarded logs; survives flush, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (!flush_i) begin
      drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

  assign log_o       = mem[rd_ptr_q];
  assign log_valid_o = (count_q != '0);
  assign level_o     = count_q;
  assign stall_o     = stall_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_cfi_log_queue.sv
// Testbench for cfi_log_queue: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a queue-based reference model.
`timescale 1ns/1ps
module tb_cfi_log_queue;
  import cfi_log_pkg::*;

  localparam int unsigned NRP = 2;
  localparam int unsigned DEP = 8;
  localparam int unsigned NRA = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   flush_i;
  logic [NRP*SBE_W-1:0]   instr_i;
  logic [NRP-1:0]         commit_ack_i;
  logic [FLAGS_W-1:0]     flags_m_i, flags_h_i, flags_s_i, flags_u_i;
  logic [1:0]             priv_lvl_i;
  logic [NRA*VLEN-1:0]    range_start_i, range_limit_i;
  logic [NRA-1:0]         range_en_i;
  logic [LOG_W-1:0]       log_o;
  logic                   log_valid_o;
  logic                   log_ready_i;
  logic [$clog2(DEP):0]   level_o;
  logic                   stall_o;
  logic                   overflow_o;
`ifdef CFI_LOG_DROP_CNT_EN
  logic [15:0]            drop_cnt_o;
`endif

  cfi_log_queue #(.NR_COMMIT_PORTS(NRP), .DEPTH(DEP), .NR_ADDR_RANGES(NRA)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .instr_i(instr_i),
    .commit_ack_i(commit_ack_i), .flags_m_i(flags_m_i), .flags_h_i(flags_h_i),
    .flags_s_i(flags_s_i), .flags_u_i(flags_u_i), .priv_lvl_i(priv_lvl_i),
    .range_start_i(range_start_i), .range_limit_i(range_limit_i),
    .range_en_i(range_en_i), .log_o(log_o), .log_valid_o(log_valid_o),
    .log_ready_i(log_ready_i), .level_o(level_o), .stall_o(stall_o),
    .overflow_o(overflow_o)
`ifdef CFI_LOG_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  scoreboard_entry_t port_ent [NRP];
  logic [VLEN-1:0]   win_start [NRA];
  logic [VLEN-1:0]   win_limit [NRA];
  logic [7:0]        op_list [9] = '{OP_ADD, OP_EQ, OP_NE, OP_LTS, OP_GES,
                                     OP_LTU, OP_GEU, OP_JALR, OP_JAL};

  always_comb begin
    for (int i = 0; i < NRP; i++) instr_i[i*SBE_W +: SBE_W] = port_ent[i];
  end
  always_comb begin
    for (int j = 0; j < NRA; j++) begin
      range_start_i[j*VLEN +: VLEN] = win_start[j];
      range_limit_i[j*VLEN +: VLEN] = win_limit[j];
    end
  end

  int       checks = 0;
  int       errors = 0;
  int       m_cnt = 0;
  cfi_log_t exp_q [$];
  logic     exp_ovf = 1'b0;
  int       exp_drop = 0;
  bit       chk_en = 1'b0;
  cfi_log_t hd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic cfi_flags_t ref_flags(input scoreboard_entry_t e);
    cfi_flags_t f = '0;
    bit br, jr, jl, l1, ld;
    if (e.fu == FU_CTRL_FLOW) begin
      br = (e.op == OP_EQ) || (e.op == OP_NE) || (e.op == OP_LTS) ||
           (e.op == OP_GES) || (e.op == OP_LTU) || (e.op == OP_GEU);
      jr = (e.op == OP_JALR);
      jl = !br && !jr;
      l1 = (e.rs1 == 5'd1) || (e.rs1 == 5'd5);
      ld = (e.rd == 5'd1) || (e.rd == 5'd5);
      f.branch = br;
      f.jump   = (jl || jr) && !l1 && !ld;
      f.call   = (jl || jr) && ld;
      f.ret    = jr && l1;
    end
    return f;
  endfunction

  function automatic bit ref_qual(input int p);
    scoreboard_entry_t e = port_ent[p];
    logic [FLAGS_W-1:0] m;
    bit inwin = 1'b0;
    case (priv_lvl_i)
      PRIV_M:  m = flags_m_i;
      PRIV_HS: m = flags_h_i;
      PRIV_S:  m = flags_s_i;
      default: m = flags_u_i;
    endcase
    for (int j = 0; j < NRA; j++)
      if (range_en_i[j] && (win_start[j] <= e.pc) && (e.pc < win_limit[j])) inwin = 1'b1;
    return e.valid && commit_ack_i[p] && ((m & ref_flags(e)) != '0) && inwin;
  endfunction

  function automatic cfi_log_t ref_log(input int p);
    cfi_log_t l;
    l.flags       = ref_flags(port_ent[p]);
    l.addr_pc     = port_ent[p].pc;
    l.addr_npc    = port_ent[p].result;
    l.addr_target = port_ent[p].predict_address;
    return l;
  endfunction

  // Reference model: evaluated at every active edge with the inputs the DUT sees.
  task automatic model_edge();
    int free, acc, nd, popped;
    if (rst_i) begin
      m_cnt = 0; exp_q.delete(); exp_ovf = 1'b0; exp_drop = 0;
      return;
    end
    if (flush_i) begin
      m_cnt = 0; exp_q.delete(); exp_ovf = 1'b0;
      return;
    end
    free   = DEP - m_cnt;
    popped = (m_cnt > 0 && log_ready_i) ? 1 : 0;
    acc = 0; nd = 0;
    for (int p = 0; p < NRP; p++) begin
      if (ref_qual(p)) begin
        if (acc < free) begin exp_q.push_back(ref_log(p)); acc++; end
        else nd++;
      end
    end
    m_cnt    = m_cnt + acc - popped;
    exp_ovf  = (nd > 0);
    exp_drop = (exp_drop + nd > 65535) ? 65535 : exp_drop + nd;
  endtask

  // Monitor: status checks every cycle, head compared on every handshake.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("level", level_o, m_cnt);
      chk("valid", log_valid_o, m_cnt != 0);
      chk("stall", stall_o, (DEP - m_cnt) < NRP);
      chk("overflow", overflow_o, exp_ovf);
`ifdef CFI_LOG_DROP_CNT_EN
      chk("drop_cnt", drop_cnt_o, exp_drop);
`endif
      if (log_valid_o && log_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL head_unexpected actual=%0h required=none", log_o);
        end else begin
          chk("head", log_o, exp_q.pop_front());
        end
      end
    end
  end

  function automatic scoreboard_entry_t mk(input logic [7:0] op, input logic [4:0] rs1,
                                           input logic [4:0] rd, input logic [VLEN-1:0] pc);
    scoreboard_entry_t e;
    e.valid = 1'b1; e.fu = FU_CTRL_FLOW; e.op = op; e.rs1 = rs1; e.rd = rd;
    e.pc = pc; e.result = pc + 32'd4; e.predict_address = $urandom();
    return e;
  endfunction

  function automatic logic [4:0] rnd_reg();
    case ($urandom % 4)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic scoreboard_entry_t rnd_ent();
    scoreboard_entry_t e;
    e = mk(op_list[$urandom % 9], rnd_reg(), rnd_reg(), VLEN'($urandom_range(0, 32'h7000) & ~32'h3));
    e.valid = ($urandom % 8) != 0;
    if ($urandom % 5 == 0) e.fu = 4'd1;
    return e;
  endfunction

  task automatic idle();
    for (int p = 0; p < NRP; p++) port_ent[p] = '0;
    commit_ack_i = '0;
    flush_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic push2(input logic [VLEN-1:0] pc);
    port_ent[0] = mk(OP_JAL, 5'd0, 5'd1, pc);
    port_ent[1] = mk(OP_EQ, 5'd2, 5'd3, pc + 32'd4);
    commit_ack_i = 2'b11;
  endtask

  task automatic push1(input logic [VLEN-1:0] pc);
    port_ent[0] = mk(OP_JALR, 5'd5, 5'd0, pc);
    commit_ack_i = 2'b01;
  endtask

  initial begin
    rst_i = 1'b1; idle(); log_ready_i = 1'b0; priv_lvl_i = PRIV_M;
    flags_m_i = '0; flags_h_i = '0; flags_s_i = '0; flags_u_i = '0;
    range_en_i = '0;
    for (int j = 0; j < NRA; j++) begin win_start[j] = '0; win_limit[j] = '0; end
    step(); chk_en = 1'b1; step(); rst_i = 1'b0;
    chk("reset_log", log_o, 0);

    // Single call log appears the next cycle.
    win_start[0] = 32'h8000_0000; win_limit[0] = 32'h9000_0000; range_en_i = 4'b0001;
    flags_m_i = 4'b0010;
    port_ent[0] = mk(OP_JAL, 5'd0, 5'd1, 32'h8000_0100); commit_ack_i = 2'b01;
    step(); idle();
    hd = log_o;
    chk("single_level", level_o, 1);
    chk("single_call", hd.flags.call, 1);
    chk("single_pc", hd.addr_pc, 32'h8000_0100);
    log_ready_i = 1'b1; step(); log_ready_i = 1'b0;

    // Port order: branch then return.
    flags_m_i = 4'b1111;
    port_ent[0] = mk(OP_EQ, 5'd2, 5'd3, 32'h8000_0000);
    port_ent[1] = mk(OP_JALR, 5'd1, 5'd0, 32'h8000_0004);
    commit_ack_i = 2'b11;
    step(); idle();
    hd = log_o;
    chk("order_first_pc", hd.addr_pc, 32'h8000_0000);
    chk("order_first_branch", hd.flags.branch, 1);
    log_ready_i = 1'b1; step();
    hd = log_o;
    chk("order_second_pc", hd.addr_pc, 32'h8000_0004);
    chk("order_second_ret", hd.flags.ret, 1);
    step(); log_ready_i = 1'b0;

    // Filtering: window limit is exclusive, privilege mask, missing ack.
    port_ent[0] = mk(OP_JAL, 5'd0, 5'd1, 32'h9000_0000); commit_ack_i = 2'b01;
    step(); idle(); chk("filter_window", level_o, 0);
    priv_lvl_i = PRIV_U;
    port_ent[0] = mk(OP_JAL, 5'd0, 5'd1, 32'h8000_0200); commit_ack_i = 2'b01;
    step(); idle(); chk("filter_priv", level_o, 0);
    priv_lvl_i = PRIV_M;
    port_ent[0] = mk(OP_JAL, 5'd0, 5'd1, 32'h8000_0300); commit_ack_i = 2'b00;
    step(); idle(); chk("filter_ack", level_o, 0);

    // Overflow: fill to 7, then two logs with one free slot.
    for (int k = 0; k < 3; k++) begin push2(32'h8000_1000 + 32'(k * 8)); step(); end
    idle(); push1(32'h8000_1100); step();
    idle(); push2(32'h8000_1200); step(); idle();
    chk("ovf_level", level_o, 8);
    chk("ovf_pulse", overflow_o, 1);
    chk("ovf_stall", stall_o, 1);
`ifdef CFI_LOG_DROP_CNT_EN
    chk("ovf_drop_cnt", drop_cnt_o, 1);
`endif
    step();
    chk("ovf_one_cycle", overflow_o, 0);
    log_ready_i = 1'b1; repeat (9) step(); log_ready_i = 1'b0;

    // Pointer wrap under concurrent push and pop.
    log_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (k % 2 == 0) push2(32'h8000_2000 + 32'(k * 8));
      step();
    end
    idle(); repeat (4) step(); log_ready_i = 1'b0;
    chk("wrap_drained", level_o, 0);

    // Flush with a concurrent push, then reset.
    push2(32'h8000_3000); step(); push2(32'h8000_3008); step();
    idle(); push1(32'h8000_3010); step(); idle();
    chk("flush_pre_level", level_o, 5);
    push2(32'h8000_3020); flush_i = 1'b1; step(); idle();
    chk("flush_level", level_o, 0);
    chk("flush_valid", log_valid_o, 0);
    chk("flush_ovf", overflow_o, 0);
    push2(32'h8000_3030); step(); idle();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("rst_level", level_o, 0);
    chk("rst_log", log_o, 0);
    chk("rst_stall", stall_o, 0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 0) begin
        for (int j = 0; j < NRA; j++) begin
          int s, l;
          s = $urandom_range(0, 32'h6000);
          l = s + $urandom_range(0, 32'h2000) - 32'h400;
          win_start[j] = VLEN'(s);
          win_limit[j] = VLEN'((l < 0) ? 0 : l);
        end
        range_en_i = 4'($urandom);
      end
      if (c % 50 == 0) begin
        flags_m_i = 4'($urandom); flags_h_i = 4'($urandom);
        flags_s_i = 4'($urandom); flags_u_i = 4'($urandom);
      end
      for (int p = 0; p < NRP; p++) port_ent[p] = rnd_ent();
      commit_ack_i = 2'($urandom);
      priv_lvl_i   = 2'($urandom);
      log_ready_i  = ($urandom % 100) < ((c < 300) ? 30 : 80);
      flush_i      = ($urandom % 40) == 0;
      rst_i        = ($urandom % 200) == 0;
      step();
    end
    idle(); rst_i = 1'b0; log_ready_i = 1'b1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
